// File: rtl/multi_timer.sv
// Multi-channel count-up timer with per-channel compare, one-shot/periodic mode and a W1C pending flag.
// Optional per-channel prescaler is built only when MULTI_TIMER_PRESCALER_EN is defined.
module multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  logic [3:0]        sel_ch;
  logic [3:0]        off;
  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] ie_v;
  logic [NUM_CH-1:0] pend_v;
  logic [NUM_CH-1:0] mode_v;
  logic [CNT_W-1:0]  cnt_a [NUM_CH];
  logic [CNT_W-1:0]  val_a [NUM_CH];
`ifdef MULTI_TIMER_PRESCALER_EN
  logic [PRESC_W-1:0] presc_a [NUM_CH];
`endif
  logic              unused_bits;

  assign sel_ch      = addr_i[7:4];
  assign off         = addr_i[3:0];
  assign unused_bits = ^{addr_i[31:8], data_i};

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic             hit;
    logic             wr_ctrl;
    logic             wr_val;
    logic             tick;
    logic             expire;
    logic             en_nxt;
    logic             en;
    logic             ie;
    logic             pend;
    logic             mode;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] val;

    assign hit     = we_i && (sel_ch == 4'(n));
    assign wr_ctrl = hit && (off == 4'h0);
    assign wr_val  = hit && (off == 4'h8);
    assign expire  = tick && (cnt >= val);

`ifdef MULTI_TIMER_PRESCALER_EN
    logic               wr_presc;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    assign wr_presc = hit && (off == 4'hC);
    assign tick     = en && (pcnt == presc);

    always_ff @(posedge clk) begin
      if (!rst) begin
        presc <= '0;
        pcnt  <= '0;
      end else begin
        if (wr_presc) presc <= data_i[PRESC_W-1:0];
        // restart from zero on enable, disable and every wrap
        if (!en || !en_nxt || tick) pcnt <= '0;
        else                        pcnt <= pcnt + PRESC_W'(1);
      end
    end

    assign presc_a[n] = presc;
`else
    assign tick = en;
`endif

    // a CTRL write overrides the one-shot auto-disable in the same cycle
    always_comb begin
      en_nxt = en;
      if (expire && !mode) en_nxt = 1'b0;
      if (wr_ctrl)         en_nxt = data_i[0];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        en   <= 1'b0;
        ie   <= 1'b0;
        pend <= 1'b0;
        mode <= 1'b0;
        cnt  <= '0;
        val  <= '0;
      end else begin
        en <= en_nxt;
        if (wr_ctrl) begin
          ie   <= data_i[1];
          mode <= data_i[3];
        end
        if (expire)                      pend <= 1'b1;
        else if (wr_ctrl && data_i[2])   pend <= 1'b0;
        if (wr_val) val <= data_i[CNT_W-1:0];
        if (!en_nxt || expire) cnt <= '0;
        else if (tick)         cnt <= cnt + CNT_W'(1);
      end
    end

    assign en_v[n]   = en;
    assign ie_v[n]   = ie;
    assign pend_v[n] = pend;
    assign mode_v[n] = mode;
    assign cnt_a[n]  = cnt;
    assign val_a[n]  = val;
  end

  always_comb begin
    data_o = '0;
    if (rst) begin
      if (addr_i[7:0] == 8'hF0) begin
        data_o = 32'(pend_v);
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (sel_ch == 4'(n)) begin
            case (off)
              4'h0:    data_o = {28'b0, mode_v[n], pend_v[n], ie_v[n], en_v[n]};
              4'h4:    data_o = 32'(cnt_a[n]);
              4'h8:    data_o = 32'(val_a[n]);
`ifdef MULTI_TIMER_PRESCALER_EN
              4'hC:    data_o = 32'(presc_a[n]);
`endif
              default: data_o = '0;
            endcase
          end
        end
      end
    end
  end

  assign int_sig_o = rst && (|(pend_v & ie_v));

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Parametrised successor of the single 32-bit count-up peripheral timer.
- NUM_CH independent count-up channels, each with:
  - programmable width;
  - optional clock prescaler;
  - one-shot or periodic (auto-reload) mode;
  - write-1-to-clear pending flag.
- Sits on the core's peripheral bus with the same flat data/addr/we interface.
- Drives a single level interrupt into the core: the OR of all enabled pending channels.

Parameters:
- NUM_CH, 4, number of timer channels (1..15).
- CNT_W, 32, counter/compare width per channel (8..32); upper read bits return zero.
- PRESC_W, 16, prescaler register width (1..32).

Ports:
- clk  input  1  single system clock.
- rst  input  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- data_i  input  32  write data.
- addr_i  input  32  byte address; only addr_i[7:0] decoded.
- we_i  input  1  write strobe, one cycle per write.
- data_o  output  32  combinational read data for addr_i.
- int_sig_o  output  1  level interrupt, asserted while any channel has pending=1 and int enable=1.

Behaviour:
- Register map:
  - Channel n base = 0x10*n.
  - +0x0 CTRL: [0] enable, [1] int enable, [2] pending (W1C), [3] mode (0 one-shot, 1 periodic); other bits read 0.
  - +0x4 COUNT: read-only.
  - +0x8 VALUE: compare.
  - +0xC PRESC.
  - 0xF0 STATUS: read-only; bit n = pending of channel n.
  - Unmapped offsets: read 0, writes ignored.
- Reset (rst=0):
  - All CTRL, COUNT, VALUE, PRESC and prescaler counters go to 0.
  - data_o=0 while rst=0; int_sig_o=0.
- Prescaler tick: when enable=1, internal prescaler counts 0..PRESC, then wraps and produces a one-cycle tick. PRESC=0 gives a tick every cycle.
- Counter:
  - On tick, if COUNT >= VALUE, the channel expires; otherwise COUNT increments by 1.
  - On expiry:
    - COUNT <= 0 and pending <= 1.
    - One-shot: enable <= 0.
    - Periodic: enable stays 1.
  - Consequence: with PRESC=0, expiry occurs VALUE+1 cycles after enable.
  - VALUE=0 expires on the first tick.
- Enable and counter-clear rules:
  - enable=0: COUNT and prescaler held at 0.
  - Writing enable 0->1 starts from COUNT=0, prescaler=0.
  - Writing enable=1 while already 1 does not clear COUNT.
- Simultaneous events:
  - A CTRL write in the same cycle as expiry: bits [3,1,0] take the written value (software wins, including auto-clear of enable).
  - Pending: hardware set wins over a W1C in the same cycle, so no interrupt is lost.
- VALUE written below the current COUNT: the channel expires on the next tick.
- Width handling:
  - COUNT/VALUE are truncated to CNT_W on write; PRESC is truncated to PRESC_W.
  - Reads are zero-extended to 32 bits.
- No wrap beyond the VALUE compare; COUNT never exceeds VALUE except transiently after a VALUE write.
- int_sig_o is combinational from the registers and has no extra latency.
- A write to a channel affects only that channel.

Optional Feature:
- Macro: MULTI_TIMER_PRESCALER_EN.
- Defined: PRESC registers and per-channel prescaler counters exist as described.
- Undefined:
  - No prescaler logic; ticks occur every cycle while enabled.
  - PRESC offsets read 0 and ignore writes.

Test Plan:
- Reset: rst=0 for 2 cycles -> all reads 0, int_sig_o=0; STATUS=0.
- Channel 0 one-shot:
  - Stimulus: VALUE=5, PRESC=0, CTRL=0x3.
  - Response: pending=1 exactly 6 cycles after the write; CTRL reads 0x6; int_sig_o=1.
  - Then write CTRL=0x4 -> pending cleared, int_sig_o=0.
- Channel 1 periodic:
  - Stimulus: VALUE=3, PRESC=1, CTRL=0xB.
  - Response: expiry every 8 cycles; enable remains 1; STATUS bit1=1.
  - W1C in the same cycle as a new expiry -> pending still 1.
- Independence:
  - Stimulus: ch2 VALUE=10 and ch3 VALUE=2, both enabled, int enable only on ch2.
  - Response: ch3 pending at 3 cycles with int_sig_o=0; int_sig_o rises when ch2 expires at 11 cycles.
- Boundaries:
  - VALUE=0 -> expiry on the first tick.
  - Write VALUE=4 while COUNT=7 -> expiry next tick.
  - With CNT_W=8, write VALUE=0x1FF -> reads 0xFF.
  - Reset asserted mid-count -> COUNT=0, enable=0.
